// File: rtl/rv_alu_pkg.sv
// Shared types for the two-requester ALU scheduler: op codes, FSM states and
// the latched request record.
package rv_alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_SHL = 4'd5
  } alu_op_e;

  localparam int ALU_OP_MAX = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } sched_state_e;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [4:0]  addr;
    logic        reg_mem_n;
    logic        id;
  } req_t;

  function automatic logic op_is_legal(input logic [3:0] op, input int op_max);
    return ({28'd0, op} <= 32'(op_max));
  endfunction

endpackage

// File: rtl/rv_rr_arb2.sv
// Two-way round-robin arbiter; the remembered winner only moves when the
// grant is actually taken, so a tie always goes to the other requester.
module rv_rr_arb2 (
  input  logic clk,
  input  logic reset,
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_accept,
  output logic o_grant_any,
  output logic o_grant_id
);

  logic r_last_grant;
  logic w_grant_id;

  always_comb begin
    w_grant_id = 1'b0;
    if (i_req0 && i_req1) begin
      w_grant_id = ~r_last_grant;
    end else begin
      w_grant_id = i_req1;
    end
  end

  // Reset to 1 so req0 wins the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_grant <= 1'b1;
    end else if (i_accept && (i_req0 || i_req1)) begin
      r_last_grant <= w_grant_id;
    end
  end

  assign o_grant_any = i_req0 | i_req1;
  assign o_grant_id  = w_grant_id;

endmodule

// File: rtl/rv_alu_sched.sv
// Shares one ALU between FDU issue (req0) and address-gen (req1): one op in
// flight, tagged responses, illegal-op / timeout / address-echo checking.
module rv_alu_sched
  import rv_alu_pkg::*;
#(
  parameter int TIMEOUT_CYC = 8,
  parameter int OP_MAX      = ALU_OP_MAX
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic [3:0]  req0_op,
  input  logic [31:0] req0_in1,
  input  logic [31:0] req0_in2,
  input  logic [4:0]  req0_addr,
  input  logic        req0_reg_mem_n,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [3:0]  req1_op,
  input  logic [31:0] req1_in1,
  input  logic [31:0] req1_in2,
  input  logic [4:0]  req1_addr,
  input  logic        req1_reg_mem_n,
  output logic        req1_ready,
  output logic        alu_op_valid,
  output logic [3:0]  alu_op,
  output logic [31:0] alu_in1,
  output logic [31:0] alu_in2,
  output logic [4:0]  alu_addr,
  output logic        alu_reg_mem_n,
  input  logic        alu_rdy,
  input  logic        alu_result_valid,
  input  logic [31:0] alu_result,
  input  logic [31:0] alu_result_addr,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [31:0] rsp_result,
  output logic [4:0]  rsp_addr,
  output logic        rsp_reg_mem_n,
  output logic        rsp_err,
  output logic        err_timeout,
  output logic        err_stray
);

  localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);

  sched_state_e r_state, w_state_next;
  req_t         r_req, w_sel;
  logic [31:0]  r_result;
  logic         r_err;
  logic [TW-1:0] r_timer;
  logic         r_err_timeout;
  logic         r_err_stray;

  logic w_grant_any, w_grant_id, w_accept, w_legal, w_timeout;
  logic w_unused;

  // alu_rdy is advisory and only the low address bits are echoed back.
  assign w_unused = ^{alu_rdy, alu_result_addr[31:5]};

  rv_rr_arb2 u_arb (
    .clk        (clk),
    .reset      (reset),
    .i_req0     (req0_valid),
    .i_req1     (req1_valid),
    .i_accept   (w_accept),
    .o_grant_any(w_grant_any),
    .o_grant_id (w_grant_id)
  );

  assign w_accept  = (r_state == IDLE) && w_grant_any && !reset;
  assign w_legal   = op_is_legal(w_sel.op, OP_MAX);
  assign w_timeout = (r_state == WAIT) && !alu_result_valid && (r_timer == TIMER_LAST);

  always_comb begin
    w_sel = '0;
    if (w_grant_id) begin
      w_sel = '{op: req1_op, in1: req1_in1, in2: req1_in2, addr: req1_addr,
                reg_mem_n: req1_reg_mem_n, id: 1'b1};
    end else begin
      w_sel = '{op: req0_op, in1: req0_in1, in2: req0_in2, addr: req0_addr,
                reg_mem_n: req0_reg_mem_n, id: 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:  if (w_accept) w_state_next = w_legal ? ISSUE : RESP;
      ISSUE: w_state_next = WAIT;
      WAIT:  if (alu_result_valid || w_timeout) w_state_next = RESP;
      RESP:  w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_req         <= '0;
      r_result      <= '0;
      r_err         <= 1'b0;
      r_timer       <= '0;
      r_err_timeout <= 1'b0;
      r_err_stray   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_req    <= w_sel;
        r_result <= '0;
        r_err    <= !w_legal;
      end
      if (r_state == ISSUE) begin
        r_timer <= '0;
      end
      if (r_state == WAIT) begin
        r_timer <= r_timer + 1'b1;
        if (alu_result_valid) begin
          r_result <= alu_result;
          if (alu_result_addr[4:0] != r_req.addr) r_err <= 1'b1;
        end else if (w_timeout) begin
          r_err         <= 1'b1;
          r_err_timeout <= 1'b1;
        end
      end
      // A strobe outside WAIT also catches a result arriving after a timeout.
      if (alu_result_valid && (r_state != WAIT)) begin
        r_err_stray <= 1'b1;
      end
    end
  end

  always_comb begin
    req0_ready    = w_accept && !w_grant_id;
    req1_ready    = w_accept && w_grant_id;
    alu_op_valid  = 1'b0;
    alu_op        = '0;
    alu_in1       = '0;
    alu_in2       = '0;
    alu_addr      = '0;
    alu_reg_mem_n = 1'b0;
    rsp_valid     = 1'b0;
    rsp_id        = 1'b0;
    rsp_result    = '0;
    rsp_addr      = '0;
    rsp_reg_mem_n = 1'b0;
    rsp_err       = 1'b0;
    if (r_state == ISSUE) begin
      alu_op_valid  = 1'b1;
      alu_op        = r_req.op;
      alu_in1       = r_req.in1;
      alu_in2       = r_req.in2;
      alu_addr      = r_req.addr;
      alu_reg_mem_n = r_req.reg_mem_n;
    end
    if (r_state == RESP) begin
      rsp_valid     = 1'b1;
      rsp_id        = r_req.id;
      rsp_result    = r_err ? 32'd0 : r_result;
      rsp_addr      = r_req.addr;
      rsp_reg_mem_n = r_req.reg_mem_n;
      rsp_err       = r_err;
    end
  end

  assign err_timeout = r_err_timeout;
  assign err_stray   = r_err_stray;

endmodule

// File: tb/tb_rv_alu_sched.sv
// Directed bench for rv_alu_sched: drivers push expected responses into a
// scoreboard queue, a negedge monitor pops and compares on every rsp_valid.
module tb_rv_alu_sched;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [3:0]  req0_op = '0, req1_op = '0;
  logic [31:0] req0_in1 = '0, req0_in2 = '0, req1_in1 = '0, req1_in2 = '0;
  logic [4:0]  req0_addr = '0, req1_addr = '0;
  logic        req0_reg_mem_n = 1'b0, req1_reg_mem_n = 1'b0;
  logic        req0_ready, req1_ready;
  logic        alu_op_valid;
  logic [3:0]  alu_op;
  logic [31:0] alu_in1, alu_in2;
  logic [4:0]  alu_addr;
  logic        alu_reg_mem_n;
  logic        alu_rdy = 1'b1;
  logic        alu_result_valid = 1'b0;
  logic [31:0] alu_result = '0;
  logic [31:0] alu_result_addr = '0;
  logic        rsp_valid, rsp_id, rsp_reg_mem_n, rsp_err;
  logic [31:0] rsp_result;
  logic [4:0]  rsp_addr;
  logic        err_timeout, err_stray;

  rv_alu_sched #(.TIMEOUT_CYC(8), .OP_MAX(5)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_op(req0_op), .req0_in1(req0_in1), .req0_in2(req0_in2),
    .req0_addr(req0_addr), .req0_reg_mem_n(req0_reg_mem_n), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_op(req1_op), .req1_in1(req1_in1), .req1_in2(req1_in2),
    .req1_addr(req1_addr), .req1_reg_mem_n(req1_reg_mem_n), .req1_ready(req1_ready),
    .alu_op_valid(alu_op_valid), .alu_op(alu_op), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_addr(alu_addr), .alu_reg_mem_n(alu_reg_mem_n), .alu_rdy(alu_rdy),
    .alu_result_valid(alu_result_valid), .alu_result(alu_result),
    .alu_result_addr(alu_result_addr),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_addr(rsp_addr),
    .rsp_reg_mem_n(rsp_reg_mem_n), .rsp_err(rsp_err),
    .err_timeout(err_timeout), .err_stray(err_stray)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        id;
    logic [31:0] result;
    logic [4:0]  addr;
    logic        rm;
    logic        err;
    int          lat;
    int          acc_cyc;
  } exp_t;

  exp_t sb[$];
  int   rsp_order[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   n_issue = 0;
  int   last_issue_cyc = 0;
  int   acc_cyc_last = 0;
  int   stub_mode = 0;   // 0 normal, 1 silent, 2 wrong address echo
  logic stray_req = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] stub_alu(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return a << b[4:0];
      default: return 32'd0;
    endcase
  endfunction

  // ALU stub: result strobe two cycles after the issue pulse.
  logic        s1 = 1'b0;
  logic [3:0]  s_op = '0;
  logic [31:0] s_a = '0, s_b = '0;
  logic [4:0]  s_addr = '0;
  always @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b0;
      alu_result_valid <= 1'b0;
    end else begin
      s1     <= alu_op_valid && (stub_mode != 1);
      s_op   <= alu_op;
      s_a    <= alu_in1;
      s_b    <= alu_in2;
      s_addr <= alu_addr;
      alu_result_valid <= s1 || stray_req;
      alu_result       <= stub_alu(s_op, s_a, s_b);
      alu_result_addr  <= (stub_mode == 2) ? 32'd9 : {27'd0, s_addr};
    end
  end

  // Monitor / scoreboard checker.
  always @(negedge clk) begin
    exp_t e;
    if (alu_op_valid) begin
      n_issue++;
      last_issue_cyc = cyc;
    end
    if (rsp_valid) begin
      if (sb.size() == 0) begin
        check("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        rsp_order.push_back(int'(rsp_id));
        check("rsp_id", 32'(rsp_id), 32'(e.id));
        check("rsp_result", rsp_result, e.result);
        check("rsp_addr", 32'(rsp_addr), 32'(e.addr));
        check("rsp_reg_mem_n", 32'(rsp_reg_mem_n), 32'(e.rm));
        check("rsp_err", 32'(rsp_err), 32'(e.err));
        if (e.lat > 0) check("rsp_latency", 32'(cyc - e.acc_cyc), 32'(e.lat));
        $display("[TB] rsp id=%0d result=%0h addr=%0d err=%0d at cycle %0d",
                 rsp_id, rsp_result, rsp_addr, rsp_err, cyc);
      end
    end
  end

  task automatic set_req(input logic id, input logic v, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] addr, input logic rm);
    if (id) begin
      req1_valid = v; req1_op = op; req1_in1 = a; req1_in2 = b;
      req1_addr = addr; req1_reg_mem_n = rm;
    end else begin
      req0_valid = v; req0_op = op; req0_in1 = a; req0_in2 = b;
      req0_addr = addr; req0_reg_mem_n = rm;
    end
  endtask

  // Present a request, wait for its ready, log the expectation at accept time.
  task automatic drive(input logic id, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] addr, input logic rm,
                       input logic [31:0] exp_res, input logic exp_err, input int lat,
                       input bit keep);
    bit got = 0;
    int n = 0;
    exp_t e;
    set_req(id, 1'b1, op, a, b, addr, rm);
    while (!got && n < 40) begin
      @(negedge clk);
      if (id ? req1_ready : req0_ready) got = 1;
      else n++;
    end
    if (!got) begin
      check("ready_timeout", 32'd0, 32'd1);
    end else begin
      e = '{id: id, result: exp_res, addr: addr, rm: rm, err: exp_err, lat: lat, acc_cyc: cyc};
      sb.push_back(e);
      acc_cyc_last = cyc;
    end
    @(posedge clk);
    #1;
    if (!keep) set_req(id, 1'b0, op, a, b, addr, rm);
  endtask

  task automatic wait_done();
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check("rsp_missing", 32'(sb.size()), 32'd0);
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    int issues_before;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_alu_op_valid", 32'(alu_op_valid), 32'd0);
    check("reset_alu_in1", alu_in1, 32'd0);
    check("reset_rsp_result", rsp_result, 32'd0);
    check("reset_ready0", 32'(req0_ready), 32'd0);
    check("reset_ready1", 32'(req1_ready), 32'd0);
    check("reset_err_timeout", 32'(err_timeout), 32'd0);
    check("reset_err_stray", 32'(err_stray), 32'd0);
    @(posedge clk);
    #1;

    // Both requesters contend right after reset: strict 0/1/0/1.
    rsp_order.delete();
    fork
      begin
        drive(1'b0, 4'd0, 32'd1, 32'd2, 5'd1, 1'b1, 32'd3, 1'b0, 4, 1'b1);
        drive(1'b0, 4'd1, 32'd9, 32'd4, 5'd4, 1'b1, 32'd5, 1'b0, 4, 1'b0);
      end
      begin
        drive(1'b1, 4'd2, 32'h0000_F0F0, 32'h0000_0FF0, 5'd2, 1'b0, 32'h0000_00F0, 1'b0, 4, 1'b1);
        drive(1'b1, 4'd3, 32'h0000_F000, 32'h0000_000F, 5'd6, 1'b0, 32'h0000_F00F, 1'b0, 4, 1'b0);
      end
    join
    wait_done();
    check("rr_count", 32'(rsp_order.size()), 32'd4);
    for (int i = 0; i < rsp_order.size() && i < 4; i++) begin
      check("rr_order", 32'(rsp_order[i]), 32'(i % 2));
    end

    // Single ADD: issue one cycle after accept, response four after.
    drive(1'b0, 4'd0, 32'd5, 32'd7, 5'd3, 1'b1, 32'd12, 1'b0, 4, 1'b0);
    wait_done();
    check("issue_latency", 32'(last_issue_cyc - acc_cyc_last), 32'd1);

    // Shift op exercises the top legal code.
    drive(1'b1, 4'd5, 32'd3, 32'd4, 5'd17, 1'b0, 32'd48, 1'b0, 4, 1'b0);
    wait_done();

    // Illegal op: error response next cycle, no ALU issue.
    issues_before = n_issue;
    drive(1'b1, 4'hA, 32'd1, 32'd2, 5'd7, 1'b1, 32'd0, 1'b1, 1, 1'b0);
    wait_done();
    check("illegal_no_issue", 32'(n_issue), 32'(issues_before));

    // Silent ALU: timeout after 8 WAIT cycles, then a late strobe is stray.
    stub_mode = 1;
    drive(1'b0, 4'd0, 32'd1, 32'd1, 5'd5, 1'b1, 32'd0, 1'b1, 10, 1'b0);
    wait_done();
    stub_mode = 0;
    check("timeout_sticky", 32'(err_timeout), 32'd1);
    check("stray_before", 32'(err_stray), 32'd0);
    stray_req = 1'b1;
    @(posedge clk);
    #1 stray_req = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("stray_set", 32'(err_stray), 32'd1);
    check("timeout_still", 32'(err_timeout), 32'd1);
    @(posedge clk);
    #1;

    // Address echo mismatch.
    stub_mode = 2;
    drive(1'b0, 4'd0, 32'd2, 32'd2, 5'd3, 1'b0, 32'd0, 1'b1, 4, 1'b0);
    wait_done();
    stub_mode = 0;

    // Reset while waiting on the ALU.
    drive(1'b0, 4'd0, 32'd8, 32'd8, 5'd12, 1'b1, 32'd16, 1'b0, 4, 1'b0);
    n = 0;
    while (!alu_op_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("reset_test_issue_seen", 32'(alu_op_valid), 32'd1);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    sb.delete();
    @(negedge clk);
    check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("midrst_alu_op_valid", 32'(alu_op_valid), 32'd0);
    check("midrst_alu_addr", 32'(alu_addr), 32'd0);
    check("midrst_ready0", 32'(req0_ready), 32'd0);
    check("midrst_err_timeout", 32'(err_timeout), 32'd0);
    check("midrst_err_stray", 32'(err_stray), 32'd0);
    repeat (3) @(negedge clk);
    check("midrst_no_late_rsp", 32'(rsp_valid), 32'd0);
    @(posedge clk);
    #1;
    drive(1'b0, 4'd1, 32'd10, 32'd4, 5'd8, 1'b1, 32'd6, 1'b0, 4, 1'b0);
    wait_done();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
